// File: rtl/ahb_lite_decoder_mux_if.sv
// rtl/ahb_lite_decoder_mux_if.sv - AHB-Lite master-side and slave-array signal bundle for the decoder/mux
interface ahb_lite_decoder_mux_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic [1:0]        HSEL;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA_S0;
    logic [DATA_W-1:0] HRDATA_S1;
    logic              HREADYOUT_S0;
    logic              HREADYOUT_S1;
    logic              HRESP_S0;
    logic              HRESP_S1;

    // Interconnect view: takes master requests and slave responses, drives selects and muxed response
    modport slave (
        input  HADDR, HTRANS, HRDATA_S0, HRDATA_S1, HREADYOUT_S0, HREADYOUT_S1, HRESP_S0, HRESP_S1,
        output HSEL, HREADY, HRDATA, HRESP
    );

    modport master (
        output HADDR, HTRANS, HRDATA_S0, HRDATA_S1, HREADYOUT_S0, HREADYOUT_S1, HRESP_S0, HRESP_S1,
        input  HSEL, HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahb_lite_decoder_mux.sv
// rtl/ahb_lite_decoder_mux.sv - AHB-Lite decoder, response mux and default slave; AHB_DECODE_ERR_LOG_EN adds error logging
module ahb_lite_decoder_mux #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S0_MASK = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] S1_BASE = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] S1_MASK = 32'hF000_0000
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    ahb_lite_decoder_mux_if.slave      bus
`ifdef AHB_DECODE_ERR_LOG_EN
    ,
    output logic [ADDR_W-1:0]          ERR_ADDR,
    output logic [15:0]                ERR_CNT
`endif
);

    typedef enum logic [1:0] {DS_NONE, DS_S0, DS_S1, DS_DEF} dsel_t;
    typedef enum logic [1:0] {DF_IDLE, DF_ERR1, DF_ERR2} dflt_t;

    dsel_t             r_dsel;
    dsel_t             w_dsel_next;
    dflt_t             r_dflt;
    dflt_t             w_dflt_next;
    logic              w_hsel0;
    logic              w_hsel1;
    logic              w_unmapped;
    logic              w_hready;
    logic              w_hresp;
    logic [DATA_W-1:0] w_hrdata;
    logic              w_def_ready;
    logic              w_def_resp;
    logic              w_err_start;
    logic              w_unused_htrans0;

    assign w_hsel0    = ((bus.HADDR & S0_MASK) == S0_BASE);
    assign w_hsel1    = ((bus.HADDR & S1_MASK) == S1_BASE) && !w_hsel0;
    assign w_unmapped = !w_hsel0 && !w_hsel1;
    assign bus.HSEL   = {w_hsel1, w_hsel0};

    // HTRANS[0] (BUSY vs IDLE, SEQ vs NONSEQ) does not affect decode or the default slave
    assign w_unused_htrans0 = bus.HTRANS[0];

    always_comb begin
        w_dsel_next = DS_DEF;
        if (w_hsel0) begin
            w_dsel_next = DS_S0;
        end else if (w_hsel1) begin
            w_dsel_next = DS_S1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel <= DS_NONE;
        end else if (w_hready) begin
            r_dsel <= w_dsel_next;
        end
    end

    always_comb begin
        w_hready = 1'b1;
        w_hresp  = 1'b0;
        w_hrdata = '0;
        case (r_dsel)
            DS_S0: begin
                w_hready = bus.HREADYOUT_S0;
                w_hresp  = bus.HRESP_S0;
                w_hrdata = bus.HRDATA_S0;
            end
            DS_S1: begin
                w_hready = bus.HREADYOUT_S1;
                w_hresp  = bus.HRESP_S1;
                w_hrdata = bus.HRDATA_S1;
            end
            DS_DEF: begin
                w_hready = w_def_ready;
                w_hresp  = w_def_resp;
            end
            default: ;
        endcase
    end

    assign bus.HREADY = w_hready;
    assign bus.HRESP  = w_hresp;
    assign bus.HRDATA = w_hrdata;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dflt <= DF_IDLE;
        end else begin
            r_dflt <= w_dflt_next;
        end
    end

    // ERR2 already drives HREADY high, so the next address phase is sampled there too
    always_comb begin
        w_dflt_next = r_dflt;
        w_def_ready = 1'b1;
        w_def_resp  = 1'b0;
        case (r_dflt)
            DF_IDLE: begin
                if (w_hready && bus.HTRANS[1] && w_unmapped) begin
                    w_dflt_next = DF_ERR1;
                end
            end
            DF_ERR1: begin
                w_def_ready = 1'b0;
                w_def_resp  = 1'b1;
                w_dflt_next = DF_ERR2;
            end
            DF_ERR2: begin
                w_def_resp = 1'b1;
                if (w_hready && bus.HTRANS[1] && w_unmapped) begin
                    w_dflt_next = DF_ERR1;
                end else begin
                    w_dflt_next = DF_IDLE;
                end
            end
            default: w_dflt_next = DF_IDLE;
        endcase
    end

    assign w_err_start = (r_dflt != DF_ERR1) && (w_dflt_next == DF_ERR1);

`ifdef AHB_DECODE_ERR_LOG_EN
    logic [ADDR_W-1:0] r_err_addr;
    logic [15:0]       r_err_cnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else if (w_err_start) begin
            r_err_addr <= bus.HADDR;
            if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign ERR_ADDR = r_err_addr;
    assign ERR_CNT  = r_err_cnt;
`else
    logic w_unused_err_start;
    assign w_unused_err_start = w_err_start;
`endif

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// tb/tb_ahb_lite_decoder_mux.sv - randomized and directed bench for ahb_lite_decoder_mux against a transfer-level model
module tb_ahb_lite_decoder_mux;

    logic HCLK;
    logic HRESETn;
    int   n_chk;
    int   n_bad;

    ahb_lite_decoder_mux_if bus ();

`ifdef AHB_DECODE_ERR_LOG_EN
    logic [31:0] ERR_ADDR;
    logic [15:0] ERR_CNT;
`endif

    ahb_lite_decoder_mux dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus.slave)
`ifdef AHB_DECODE_ERR_LOG_EN
        ,
        .ERR_ADDR(ERR_ADDR),
        .ERR_CNT (ERR_CNT)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Model: who owns the current data phase (0 none, 1 S0, 2 S1, 3 default)
    // and how many error-response cycles the default slave still owes.
    int          m_owner;
    int          m_err_left;
    int          m_cnt;
    logic [31:0] m_eaddr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int region(input logic [31:0] addr);
        int top;
        top = int'(addr / 32'h1000_0000);
        if (top == 0) return 1;
        if (top == 1) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_owner    = 0;
        m_err_left = 0;
        m_cnt      = 0;
        m_eaddr    = '0;
    endtask

    // Drive one cycle, check combinational outputs, advance model across the clock edge.
    task automatic step(input logic [31:0] addr, input logic [1:0] trans,
                        input logic r0, input logic r1, input logic p0, input logic p1,
                        input logic [31:0] d0, input logic [31:0] d1);
        int          reg_id;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        bus.HADDR        = addr;
        bus.HTRANS       = trans;
        bus.HREADYOUT_S0 = r0;
        bus.HREADYOUT_S1 = r1;
        bus.HRESP_S0     = p0;
        bus.HRESP_S1     = p1;
        bus.HRDATA_S0    = d0;
        bus.HRDATA_S1    = d1;
        #1;
        reg_id = region(addr);
        case (m_owner)
            1:       begin e_rdy = r0; e_resp = p0; e_data = d0; end
            2:       begin e_rdy = r1; e_resp = p1; e_data = d1; end
            3:       begin e_rdy = (m_err_left != 2); e_resp = (m_err_left != 0); e_data = '0; end
            default: begin e_rdy = 1'b1; e_resp = 1'b0; e_data = '0; end
        endcase
        chk("hsel",   64'(bus.HSEL),   (reg_id == 1) ? 64'd1 : (reg_id == 2) ? 64'd2 : 64'd0);
        chk("hready", 64'(bus.HREADY), 64'(e_rdy));
        chk("hresp",  64'(bus.HRESP),  64'(e_resp));
        chk("hrdata", 64'(bus.HRDATA), 64'(e_data));
        @(posedge HCLK);
        if (m_err_left == 2) begin
            m_err_left = 1;
        end else if (e_rdy && trans[1] && reg_id == 3) begin
            m_err_left = 2;
            m_eaddr    = addr;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_err_left = 0;
        end
        if (e_rdy) m_owner = reg_id;
        #1;
`ifdef AHB_DECODE_ERR_LOG_EN
        chk("err_cnt",  64'(ERR_CNT),  64'(m_cnt));
        chk("err_addr", 64'(ERR_ADDR), 64'(m_eaddr));
`endif
    endtask

    task automatic idle_ok(input logic [31:0] addr);
        step(addr, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic apply_reset();
        HRESETn = 1'b0;
        #1;
        chk("rst_hready", 64'(bus.HREADY), 64'd1);
        chk("rst_hresp",  64'(bus.HRESP),  64'd0);
        chk("rst_hrdata", 64'(bus.HRDATA), 64'd0);
        model_reset();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  top;
        n_chk = 0;
        n_bad = 0;
        model_reset();
        HRESETn          = 1'b0;
        bus.HADDR        = 32'h0000_0010;
        bus.HTRANS       = 2'b10;
        bus.HREADYOUT_S0 = 1'b0;
        bus.HREADYOUT_S1 = 1'b0;
        bus.HRESP_S0     = 1'b1;
        bus.HRESP_S1     = 1'b1;
        bus.HRDATA_S0    = 32'hAAAA_5555;
        bus.HRDATA_S1    = 32'h5555_AAAA;
        apply_reset();

        // After release, data phase is NONE: S0 stalling must not be visible
        step(32'h0000_0010, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h2);

        // S0 read with two wait states
        step(32'h0000_0010, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h0000_0010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h0000_0010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h0000_0010, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);

        // Pipelined S0 then S1
        step(32'h0000_0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h1000_0004, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h1000_0004, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h1000_0004, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h1000_0004, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1234_5678);

        // Unmapped single, then back-to-back unmapped
        step(32'h2000_0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle_ok(32'h2000_0000);
        idle_ok(32'h2000_0000);
        idle_ok(32'h2000_0000);
        step(32'h2000_0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h2000_0004, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h2000_0004, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle_ok(32'h2000_0004);
        idle_ok(32'h2000_0004);
        idle_ok(32'h2000_0004);

        // IDLE and BUSY to unmapped space never raise an error
        idle_ok(32'h2000_0000);
        step(32'h2000_0000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle_ok(32'h2000_0000);
        idle_ok(32'h0000_0000);

        // Slave ERROR passes through untouched
        step(32'h1000_0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h1000_0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        step(32'h1000_0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);

        // Reset asserted while S0 stalls its data phase
        step(32'h0000_0010, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.HREADYOUT_S0 = 1'b0;
        bus.HRESP_S0     = 1'b1;
        bus.HRDATA_S0    = 32'hFFFF_FFFF;
        #2;
        chk("pre_rst_hready", 64'(bus.HREADY), 64'd0);
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_hready", 64'(bus.HREADY), 64'd1);
        chk("mid_rst_hresp",  64'(bus.HRESP),  64'd0);
        chk("mid_rst_hrdata", 64'(bus.HRDATA), 64'd0);
        chk("mid_rst_hsel",   64'(bus.HSEL),   64'd1);
        apply_reset();

`ifdef AHB_DECODE_ERR_LOG_EN
        step(32'h3000_0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h3000_0004, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'h3000_0004, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'hF000_0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(32'hF000_0000, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle_ok(32'h0);
        idle_ok(32'h0);
        chk("log_cnt3",  64'(ERR_CNT),  64'd3);
        chk("log_addr3", 64'(ERR_ADDR), 64'hF000_0000);
`endif

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0:       top = 4'h0;
                1:       top = 4'h1;
                2:       top = 4'h2;
                3:       top = 4'h3;
                default: top = 4'hF;
            endcase
            a = {top, 28'($urandom) & 28'h0FF_FFFC};
            step(a, 2'($urandom_range(0, 3)),
                 ($urandom % 4) != 0, ($urandom % 4) != 0,
                 ($urandom % 8) == 0, ($urandom % 8) == 0,
                 $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_decoder_mux.md
Name: ahb_lite_decoder_mux

Overview:
- AHB-Lite single-master interconnect: address decoder plus slave-to-master response multiplexer for two slaves and an internal default slave.
- Sits between the master and the slave array. Drives the 2-bit HSEL vector and returns the selected slave's HRDATA/HREADY/HRESP to the master.
- Tracks the data phase separately from the address phase, so pipelined transfers to different slaves are steered correctly.
- The internal default slave answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.

Parameters:
- DATA_W, 32, data bus width
- ADDR_W, 32, address bus width
- S0_BASE, 32'h0000_0000, slave 0 base address (compared after masking)
- S0_MASK, 32'hF000_0000, slave 0 decode mask
- S1_BASE, 32'h1000_0000, slave 1 base address
- S1_MASK, 32'hF000_0000, slave 1 decode mask

Ports:
- HCLK  in  1  bus clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- HADDR  in  ADDR_W  master address-phase address
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HSEL  out  2  slave selects, bit0 = S0, bit1 = S1
- HREADY  out  1  muxed ready, to master and to all slaves' HREADY input
- HRDATA  out  DATA_W  muxed read data to master
- HRESP  out  1  muxed response to master
- HRDATA_S0 / HRDATA_S1  in  DATA_W  slave read data
- HREADYOUT_S0 / HREADYOUT_S1  in  1  slave ready outputs
- HRESP_S0 / HRESP_S1  in  1  slave responses

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous, active-low.
- Decode (combinational):
  - HSEL[0] = ((HADDR & S0_MASK) == S0_BASE).
  - HSEL[1] = ((HADDR & S1_MASK) == S1_BASE) && !HSEL[0]; S0 wins on overlap.
  - No match → default slave selected internally; HSEL = 00.
  - HSEL follows HADDR regardless of HTRANS; slaves qualify with HTRANS[1] & HREADY.
- Data-phase select register dsel ∈ {NONE, S0, S1, DEF}:
  - Loaded from the decode result only on a rising HCLK with HREADY = 1.
  - Held while HREADY = 0.
  - Reset value: NONE.
- Response mux, by dsel:
  - S0 / S1: that slave's HREADYOUT, HRESP and HRDATA.
  - DEF: default-slave HREADYOUT/HRESP, HRDATA = 0.
  - NONE: HREADY = 1, HRESP = 0, HRDATA = 0.
- Default slave FSM, states IDLE, ERR1, ERR2; reset state IDLE:
  - IDLE: readyout = 1, resp = 0. If HREADY && HTRANS[1] && unmapped → ERR1. IDLE/BUSY transfers to an unmapped address get a zero-wait OKAY.
  - ERR1: readyout = 0, resp = 1; unconditional → ERR2.
  - ERR2: readyout = 1, resp = 1. The next transfer is sampled this cycle: unmapped NONSEQ/SEQ → ERR1, else → IDLE.
  - The master may change HTRANS to IDLE during ERR1; the change is honoured in ERR2 (no further error).
- Latency:
  - Decode is zero-cycle.
  - Response switches slave exactly one HREADY-qualified edge after the address phase.
  - Back-to-back transfers to different slaves add no penalty.
- Reset asserted mid-transfer:
  - dsel → NONE, FSM → IDLE, immediately (asynchronous).
  - HREADY = 1, HRESP = 0, HRDATA = 0 while HRESETn = 0.
  - HSEL remains combinational on HADDR.
- Slave ERROR (HRESP_Sx = 1) is passed through unmodified; two-cycle compliance is the slave's responsibility.

Optional Feature:
- Macro: AHB_DECODE_ERR_LOG_EN.
- Defined:
  - Adds outputs ERR_ADDR (ADDR_W) and ERR_CNT (16).
  - On each IDLE→ERR1 or ERR2→ERR1 entry, ERR_ADDR captures the faulting HADDR and ERR_CNT increments, saturating at 16'hFFFF.
  - Both reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: HRESETn = 0 with HREADYOUT_S0 = 0 → HREADY = 1, HRESP = 0, HRDATA = 0; after release, dsel = NONE.
- NONSEQ read 0x0000_0010 with S0 holding HREADYOUT_S0 = 0 for 2 cycles and HRDATA_S0 = 0xDEADBEEF:
  - Address phase: HSEL = 01.
  - HREADY low 2 data cycles, then HREADY = 1 and HRDATA = 0xDEADBEEF.
- Pipelined NONSEQ 0x0000_0000 then 0x1000_0004:
  - HSEL = 10 during the S0 data phase.
  - HREADY follows S0 until S0 completes, then S1; HRDATA_S1 = 0x12345678 returned on S1 completion.
- NONSEQ to unmapped 0x2000_0000:
  - Data cycle 1: HREADY = 0, HRESP = 1. Data cycle 2: HREADY = 1, HRESP = 1. Following IDLE → HRESP = 0.
  - Back-to-back unmapped transfers → two consecutive ERROR pairs.
- HTRANS = IDLE at 0x2000_0000 → HREADY = 1, HRESP = 0, no ERR1 entry; BUSY at the same address gives the same result.
- With AHB_DECODE_ERR_LOG_EN: three unmapped NONSEQs at 0x3000_0000, 0x3000_0004, 0xF000_0000 → ERR_CNT = 3, ERR_ADDR = 0xF000_0000.
